// File: rtl/spi_frame_datapath_if.sv
// Register-side bus of the SPI frame datapath: FIFO push/pop, status, watermarks and flags.
interface spi_frame_datapath_if #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
);
  logic              tx_wr_i;
  logic [DATA_W-1:0] tx_wdata_i;
  logic              rx_rd_i;
  logic [DATA_W-1:0] rx_rdata_o;
  logic              tx_full_o;
  logic              tx_empty_o;
  logic              rx_full_o;
  logic              rx_empty_o;
  logic [CNT_W-1:0]  tx_count_o;
  logic [CNT_W-1:0]  rx_count_o;
  logic [CNT_W-1:0]  tx_wm_i;
  logic [CNT_W-1:0]  rx_wm_i;
  logic              tx_mark_o;
  logic              rx_mark_o;
  logic              tx_ovf_o;
  logic              tx_udf_o;
  logic              rx_ovf_o;
  logic              clear_flags_i;

  // Register-update logic side.
  modport master (
    output tx_wr_i, tx_wdata_i, rx_rd_i, tx_wm_i, rx_wm_i, clear_flags_i,
    input  rx_rdata_o, tx_full_o, tx_empty_o, rx_full_o, rx_empty_o, tx_count_o, rx_count_o,
    input  tx_mark_o, rx_mark_o, tx_ovf_o, tx_udf_o, rx_ovf_o
  );

  // Datapath side.
  modport slave (
    input  tx_wr_i, tx_wdata_i, rx_rd_i, tx_wm_i, rx_wm_i, clear_flags_i,
    output rx_rdata_o, tx_full_o, tx_empty_o, rx_full_o, rx_empty_o, tx_count_o, rx_count_o,
    output tx_mark_o, rx_mark_o, tx_ovf_o, tx_udf_o, rx_ovf_o
  );
endinterface

// File: rtl/spi_frame_datapath.sv
// SPI frame datapath: full-duplex shift engine, TX/RX FIFOs, watermarks and sticky error flags.
// Optional feature macro SPI_LOOPBACK_EN adds loopback_i (sample mosi_o instead of miso_i).
module spi_frame_datapath #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef SPI_LOOPBACK_EN
  input  logic loopback_i,
`endif
  input  logic miso_i,
  output logic mosi_o,
  input  logic frame_start_i,
  input  logic launch_i,
  input  logic sample_i,
  input  logic lsb_first_i,
  output logic busy_o,
  output logic frame_done_o,
  spi_frame_datapath_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] Depth   = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LastBit = BIT_W'(DATA_W - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q;
  logic              busy_q, done_q, mosi_q, lsb_q;
  logic [DATA_W-1:0] tx_sr_q, rx_sr_q;
  logic [BIT_W-1:0]  bit_cnt_q;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_wr_ptr_q, tx_rd_ptr_q, rx_wr_ptr_q, rx_rd_ptr_q;
  logic [CNT_W-1:0]  tx_count_q, rx_count_q;
  logic              tx_mark_q, rx_mark_q;
  logic              tx_ovf_q, tx_udf_q, rx_ovf_q;

  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              start_go, last_sample, sample_bit;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              tx_ovf_set, tx_udf_set, rx_ovf_set;
  logic [DATA_W-1:0] rx_word;

  assign tx_full  = (tx_count_q == Depth);
  assign tx_empty = (tx_count_q == '0);
  assign rx_full  = (rx_count_q == Depth);
  assign rx_empty = (rx_count_q == '0);

  assign start_go    = frame_start_i && (state_q == StIdle);
  assign last_sample = (state_q == StShift) && sample_i && (bit_cnt_q == LastBit);

`ifdef SPI_LOOPBACK_EN
  assign sample_bit = loopback_i ? mosi_q : miso_i;
`else
  assign sample_bit = miso_i;
`endif

  // Word as it stands after this cycle's sample, so the final bit lands in the RX FIFO.
  assign rx_word = lsb_q ? {sample_bit, rx_sr_q[DATA_W-1:1]}
                         : {rx_sr_q[DATA_W-2:0], sample_bit};

  // A pop frees the slot a simultaneous push needs, so a full FIFO still accepts it.
  assign tx_pop     = start_go && !tx_empty;
  assign tx_push    = bus.tx_wr_i && (!tx_full || tx_pop);
  assign tx_ovf_set = bus.tx_wr_i && tx_full && !tx_pop;
  assign tx_udf_set = start_go && tx_empty;
  assign rx_pop     = bus.rx_rd_i && !rx_empty;
  assign rx_push    = last_sample && (!rx_full || rx_pop);
  assign rx_ovf_set = last_sample && rx_full && !rx_pop;

  // Frame sequencer: IDLE/SHIFT with registered mosi, busy and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mosi_q    <= 1'b0;
      lsb_q     <= 1'b0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          mosi_q <= 1'b0;
          if (frame_start_i) begin
            state_q   <= StShift;
            busy_q    <= 1'b1;
            tx_sr_q   <= tx_empty ? '0 : tx_mem[tx_rd_ptr_q];
            lsb_q     <= lsb_first_i;
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
          end
        end
        StShift: begin
          if (launch_i) begin
            mosi_q  <= lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
            tx_sr_q <= lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
          end
          if (sample_i) begin
            rx_sr_q   <= rx_word;
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == LastBit) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              mosi_q  <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // FIFO storage; contents need no reset since reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= bus.tx_wdata_i;
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_word;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + PTR_W'(1);
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + PTR_W'(1);
      tx_count_q <= tx_count_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
      rx_count_q <= rx_count_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
    end
  end

  // Watermark flags, registered from the registered counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_mark_q <= 1'b1;
      rx_mark_q <= 1'b0;
    end else begin
      tx_mark_q <= (tx_count_q <= bus.tx_wm_i);
      rx_mark_q <= (rx_count_q >= bus.rx_wm_i) && (rx_count_q != '0);
    end
  end

  // Sticky error flags; a set in the clearing cycle takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf_q <= 1'b0;
      tx_udf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_set | (tx_ovf_q & ~bus.clear_flags_i);
      tx_udf_q <= tx_udf_set | (tx_udf_q & ~bus.clear_flags_i);
      rx_ovf_q <= rx_ovf_set | (rx_ovf_q & ~bus.clear_flags_i);
    end
  end

  assign mosi_o       = mosi_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

  assign bus.rx_rdata_o = rx_empty ? '0 : rx_mem[rx_rd_ptr_q];
  assign bus.tx_full_o  = tx_full;
  assign bus.tx_empty_o = tx_empty;
  assign bus.rx_full_o  = rx_full;
  assign bus.rx_empty_o = rx_empty;
  assign bus.tx_count_o = tx_count_q;
  assign bus.rx_count_o = rx_count_q;
  assign bus.tx_mark_o  = tx_mark_q;
  assign bus.rx_mark_o  = rx_mark_q;
  assign bus.tx_ovf_o   = tx_ovf_q;
  assign bus.tx_udf_o   = tx_udf_q;
  assign bus.rx_ovf_o   = rx_ovf_q;
endmodule
